// File: rtl/enemy_hp_tracker.sv
// Enemy HP tracker: applies gauge damage to enemy HP with floor at 0, animates the
// displayed HP bar down one point per DRAIN_DIV cycles, holds, then ends the turn.
module enemy_hp_tracker #(
    parameter int unsigned MAX_HP      = 100,
    parameter int unsigned DRAIN_DIV   = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pass,
    input  logic [7:0] damage,
    input  logic       refill,
    output logic [7:0] enemyHp,
    output logic [7:0] dispHp,
    output logic       miss,
    output logic       busy,
    output logic       turnDone,
    output logic       defeated,
    output logic       atkClear
);

    localparam int unsigned CNT_MAX = (DRAIN_DIV > HOLD_CYCLES) ? DRAIN_DIV : HOLD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DRAIN_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       HP_FULL   = 8'(MAX_HP);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       enemy_hp_q, enemy_hp_d;
    logic [7:0]       disp_hp_q, disp_hp_d;
    logic [7:0]       dmg_q, dmg_d;
    logic             pass_q;
    logic             miss_q, miss_d;
    logic             busy_q, busy_d;
    logic             turn_done_q, turn_done_d;
    logic             defeated_q, defeated_d;
    logic             atk_clear_q, atk_clear_d;

    logic             pass_rise;
    logic [7:0]       new_hp;
    logic [7:0]       disp_dec;

    assign pass_rise = pass & ~pass_q;
    // Saturating subtract done in 8 bits: any hit at or above current HP floors to 0.
    assign new_hp    = (dmg_q >= enemy_hp_q) ? 8'd0 : enemy_hp_q - dmg_q;
    assign disp_dec  = disp_hp_q - 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            enemy_hp_q  <= HP_FULL;
            disp_hp_q   <= HP_FULL;
            dmg_q       <= 8'd0;
            pass_q      <= 1'b0;
            miss_q      <= 1'b0;
            busy_q      <= 1'b0;
            turn_done_q <= 1'b0;
            defeated_q  <= 1'b0;
            atk_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enemy_hp_q  <= enemy_hp_d;
            disp_hp_q   <= disp_hp_d;
            dmg_q       <= dmg_d;
            pass_q      <= pass;
            miss_q      <= miss_d;
            busy_q      <= busy_d;
            turn_done_q <= turn_done_d;
            defeated_q  <= defeated_d;
            atk_clear_q <= atk_clear_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enemy_hp_d  = enemy_hp_q;
        disp_hp_d   = disp_hp_q;
        dmg_d       = dmg_q;
        miss_d      = miss_q;
        defeated_d  = defeated_q;
        turn_done_d = 1'b0;
        atk_clear_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (refill) begin
                    enemy_hp_d = HP_FULL;
                    disp_hp_d  = HP_FULL;
                    defeated_d = 1'b0;
                end else if (start && !defeated_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (pass_rise) begin
                    dmg_d   = damage;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                enemy_hp_d = new_hp;
                cnt_d      = '0;
                if (dmg_q == 8'd0) begin
                    miss_d  = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last decrement and HOLD entry share a cycle, so D points take D*DRAIN_DIV cycles.
                if (disp_hp_q <= enemy_hp_q) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    disp_hp_d = disp_dec;
                    if (disp_dec == enemy_hp_q) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d       = '0;
                    miss_d      = 1'b0;
                    turn_done_d = 1'b1;
                    atk_clear_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_HOLD) && (state_q != S_HOLD) && (enemy_hp_d == 8'd0)) begin
            defeated_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign enemyHp  = enemy_hp_q;
    assign dispHp   = disp_hp_q;
    assign miss     = miss_q;
    assign busy     = busy_q;
    assign turnDone = turn_done_q;
    assign defeated = defeated_q;
    assign atkClear = atk_clear_q;

endmodule

// File: tb/tb_enemy_hp_tracker.sv
// Bench for enemy_hp_tracker: directed turn table, multi-cycle corner sequences and
// random turns checked against a per-turn HP/timing model.
module tb_enemy_hp_tracker;

    localparam int MAX_HP = 100;
    localparam int DIV    = 4;
    localparam int HOLD   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pass;
    logic [7:0] damage;
    logic       refill;
    logic [7:0] enemyHp;
    logic [7:0] dispHp;
    logic       miss;
    logic       busy;
    logic       turnDone;
    logic       defeated;
    logic       atkClear;

    enemy_hp_tracker #(
        .MAX_HP(MAX_HP),
        .DRAIN_DIV(DIV),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pass(pass),
        .damage(damage),
        .refill(refill),
        .enemyHp(enemyHp),
        .dispHp(dispHp),
        .miss(miss),
        .busy(busy),
        .turnDone(turnDone),
        .defeated(defeated),
        .atkClear(atkClear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dmg;
        int exp_hp;
        bit exp_def;
    } vec_t;

    vec_t vecs[5];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_hp;
    bit   m_def;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One full turn from IDLE; if pass is already high it must fall and rise again.
    task automatic run_turn(input int dmg_v, input int exp_hp, input bit exp_def, input bit keep_pass);
        int old_hp, t_exp, k, miss_n;
        bit below, done;
        old_hp = m_hp;
        t_exp  = 1 + (old_hp - exp_hp) * DIV + HOLD;
        start  = 1'b1;
        if (pass) begin
            repeat (8) @(negedge clk);
            chk("held_pass_busy", int'(busy), 1);
            chk("held_pass_hp", int'(enemyHp), old_hp);
            pass = 1'b0;
        end
        @(negedge clk);
        damage = 8'(dmg_v);
        pass   = 1'b1;
        k = 0; miss_n = 0; below = 1'b0; done = 1'b0;
        while (!done && k < 2000) begin
            @(negedge clk);
            if (k == 0) chk("hp_before_commit", int'(enemyHp), old_hp);
            if (k == 1) chk("hp_commit", int'(enemyHp), exp_hp);
            if (dispHp < enemyHp) below = 1'b1;
            if (turnDone) done = 1'b1;
            else begin
                if (miss) miss_n++;
                k++;
            end
        end
        if (!done) begin
            chk("turn_timeout", 0, 1);
        end else begin
            chk("turn_cycles", k, t_exp);
            chk("atk_clear_with_done", int'(atkClear), 1);
            chk("disp_final", int'(dispHp), exp_hp);
            chk("miss_cleared_in_done", int'(miss), 0);
            chk("miss_cycles", miss_n, (dmg_v == 0) ? HOLD : 0);
            chk("disp_not_below_hp", int'(below), 0);
        end
        start = 1'b0;
        if (!keep_pass) pass = 1'b0;
        @(negedge clk);
        chk("idle_after_turn", int'(busy), 0);
        chk("done_pulse_one_cycle", int'(turnDone), 0);
        chk("clear_pulse_one_cycle", int'(atkClear), 0);
        chk("defeated_after_turn", int'(defeated), int'(exp_def));
        m_hp  = exp_hp;
        m_def = exp_def;
    endtask

    task automatic do_refill();
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        chk("refill_hp", int'(enemyHp), MAX_HP);
        chk("refill_disp", int'(dispHp), MAX_HP);
        chk("refill_defeated", int'(defeated), 0);
        m_hp  = MAX_HP;
        m_def = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  dmg, exp, r, tries;
        bit  found;
        reset = 1'b0; start = 1'b0; pass = 1'b0; refill = 1'b0; damage = 8'd0;
        vecs[0] = '{20, 80, 1'b0};
        vecs[1] = '{0, 80, 1'b0};
        vecs[2] = '{30, 50, 1'b0};
        vecs[3] = '{45, 5, 1'b0};
        vecs[4] = '{20, 0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_hp", int'(enemyHp), MAX_HP);
        chk("rst_disp", int'(dispHp), MAX_HP);
        chk("rst_busy", int'(busy), 0);
        chk("rst_miss", int'(miss), 0);
        chk("rst_done", int'(turnDone), 0);
        chk("rst_defeated", int'(defeated), 0);
        chk("rst_clear", int'(atkClear), 0);
        reset = 1'b1;
        @(negedge clk);
        m_hp = MAX_HP; m_def = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_turn(vecs[i].dmg, vecs[i].exp_hp, vecs[i].exp_def, 1'b0);
        end

        // Defeated enemy: start must not leave IDLE, flag stays sticky.
        start = 1'b1;
        repeat (5) @(negedge clk);
        chk("defeated_blocks_start", int'(busy), 0);
        chk("defeated_sticky", int'(defeated), 1);
        start = 1'b0;
        @(negedge clk);
        do_refill();

        // Pass held high across turns: only a fresh edge applies damage, once.
        run_turn(10, 90, 1'b0, 1'b1);
        run_turn(15, 75, 1'b0, 1'b0);

        // Phase abort from WAIT.
        start = 1'b1;
        @(negedge clk);
        chk("abort_wait_busy", int'(busy), 1);
        start = 1'b0;
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        chk("abort_hp", int'(enemyHp), 75);

        // Refill and start together: reload only, WAIT on the following cycle.
        refill = 1'b1; start = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        chk("refill_start_hp", int'(enemyHp), MAX_HP);
        chk("refill_start_idle", int'(busy), 0);
        @(negedge clk);
        chk("refill_start_wait", int'(busy), 1);
        start = 1'b0;
        @(negedge clk);
        chk("refill_start_back_idle", int'(busy), 0);
        m_hp = MAX_HP;

        // Async reset mid-DRAIN once dispHp reaches 90.
        start = 1'b1;
        @(negedge clk);
        damage = 8'd20; pass = 1'b1;
        found = 1'b0; tries = 0;
        while (!found && tries < 200) begin
            @(negedge clk);
            if (dispHp == 8'd90) found = 1'b1;
            tries++;
        end
        chk("reached_disp_90", int'(found), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_hp", int'(enemyHp), MAX_HP);
        chk("async_rst_disp", int'(dispHp), MAX_HP);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_miss", int'(miss), 0);
        @(negedge clk);
        reset = 1'b1; start = 1'b0; pass = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_hp", int'(enemyHp), MAX_HP);
        m_hp = MAX_HP; m_def = 1'b0;

        // Random turns against the per-turn model.
        for (int i = 0; i < 40; i++) begin
            if (m_hp == 0) do_refill();
            r = int'($urandom_range(0, 7));
            if (r == 0)      dmg = 0;
            else if (r == 1) dmg = int'($urandom_range(100, 255));
            else             dmg = int'($urandom_range(1, 30));
            exp = (dmg >= m_hp) ? 0 : m_hp - dmg;
            run_turn(dmg, exp, (exp == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
